// File: rtl/fsm_2.sv
// Four-space parking-lot controller: occupancy map, gate pulse, full blink, 7-seg/BCD status.
// Latency: occupancy and doorOpen update on the request edge; display outputs are combinational from state.
// Backpressure: none; requests are edge-triggered, and an entry into a full lot is dropped.
`timescale 1ns/1ps
module fsm_2 #(
  parameter int DOOR_CYCLES = 10,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       exit,
  input  logic [1:0] exitLocation,
  output logic       doorOpen,
  output logic       isFull,
  output logic [6:0] Capacity,
  output logic [6:0] nextParking,
  output logic [3:0] state,
  output logic [3:0] CapacityBCD,
  output logic [3:0] nextParkingBCD,
  output logic       blinkLED
);

  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  // CLOSED encodes as zero, so every register powers up in its reset value
  // on flows that zero-initialise flops.
  typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} doorState_t;

  doorState_t    doorState, doorNext;
  logic [DW-1:0] doorCnt, doorCntNext;
  logic [3:0]    occ, occNext;
  logic          enterQ, exitQ;
  logic [BW-1:0] blinkCnt;
  logic          blinkQ;

  logic [3:0]    freeMask, lowFree, exitMask;
  logic          entryOk, exitOk, accepted;

  function automatic logic [6:0] sevenSeg(input logic [3:0] v);
    case (v)
      4'd0:    sevenSeg = 7'h3F;
      4'd1:    sevenSeg = 7'h06;
      4'd2:    sevenSeg = 7'h5B;
      4'd3:    sevenSeg = 7'h4F;
      4'd4:    sevenSeg = 7'h66;
      default: sevenSeg = 7'h00;
    endcase
  endfunction

  // Entry and exit both look at the pre-edge map, so a simultaneous pair
  // never targets the same bit: entry takes a free one, exit clears a used one.
  always_comb begin
    freeMask = ~occ;
    lowFree  = freeMask & (~freeMask + 4'd1);
    exitMask = 4'b0001 << exitLocation;
    entryOk  = enter & ~enterQ & ~isFull;
    exitOk   = exit & ~exitQ & occ[exitLocation];
    accepted = entryOk | exitOk;
    occNext  = occ;
    if (entryOk) occNext = occNext | lowFree;
    if (exitOk)  occNext = occNext & ~exitMask;
  end

  always_comb begin
    doorNext    = doorState;
    doorCntNext = doorCnt;
    case (doorState)
      CLOSED: begin
        if (accepted) begin
          doorNext    = OPEN;
          doorCntNext = DW'(DOOR_CYCLES);
        end
      end
      OPEN: begin
        if (accepted) begin
          doorCntNext = DW'(DOOR_CYCLES);
        end else if (doorCnt == DW'(1)) begin
          doorNext    = CLOSED;
          doorCntNext = '0;
        end else begin
          doorCntNext = doorCnt - DW'(1);
        end
      end
      default: begin
        doorNext    = CLOSED;
        doorCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      doorState <= CLOSED;
      doorCnt   <= '0;
      occ       <= '0;
      enterQ    <= 1'b0;
      exitQ     <= 1'b0;
    end else begin
      doorState <= doorNext;
      doorCnt   <= doorCntNext;
      occ       <= occNext;
      enterQ    <= enter;
      exitQ     <= exit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blinkCnt <= '0;
      blinkQ   <= 1'b0;
    end else if (!isFull) begin
      blinkCnt <= '0;
      blinkQ   <= 1'b0;
    end else if (blinkCnt == BW'(BLINK_DIV - 1)) begin
      blinkCnt <= '0;
      blinkQ   <= ~blinkQ;
    end else begin
      blinkCnt <= blinkCnt + BW'(1);
    end
  end

  always_comb begin
    nextParkingBCD = 4'd0;
    if      (!occ[0]) nextParkingBCD = 4'd1;
    else if (!occ[1]) nextParkingBCD = 4'd2;
    else if (!occ[2]) nextParkingBCD = 4'd3;
    else if (!occ[3]) nextParkingBCD = 4'd4;
  end

  assign state       = occ;
  assign isFull      = &occ;
  assign CapacityBCD = 4'd4 - ({3'b0, occ[0]} + {3'b0, occ[1]} + {3'b0, occ[2]} + {3'b0, occ[3]});
  assign Capacity    = sevenSeg(CapacityBCD);
  assign nextParking = sevenSeg(nextParkingBCD);
  assign doorOpen    = (doorState == OPEN);
  // Gated so the LED drops on the same edge the lot stops being full.
  assign blinkLED    = blinkQ & isFull;

endmodule

// File: tb/tb_fsm_2.sv
// Randomised scoreboard bench for fsm_2: a behavioural lot model pushes expected
// outputs each clock edge, and a monitor pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_fsm_2;

  localparam int DOOR = 3;
  localparam int BLNK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0;
  logic       exitSig = 1'b0;
  logic [1:0] exitLocation = 2'd0;
  logic       doorOpen, isFull, blinkLED;
  logic [6:0] Capacity, nextParking;
  logic [3:0] state, CapacityBCD, nextParkingBCD;

  fsm_2 #(.DOOR_CYCLES(DOOR), .BLINK_DIV(BLNK)) dut (
    .clk(clk), .reset(reset), .enter(enter), .exit(exitSig), .exitLocation(exitLocation),
    .doorOpen(doorOpen), .isFull(isFull), .Capacity(Capacity), .nextParking(nextParking),
    .state(state), .CapacityBCD(CapacityBCD), .nextParkingBCD(nextParkingBCD), .blinkLED(blinkLED)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  typedef struct {
    bit [3:0] occ;
    bit       door;
    bit       blink;
  } exp_t;

  exp_t expQ[$];

  // Reference view: spaces as an array of flags, the door as "cycles left open",
  // the blink as a running count of full cycles.
  bit mOcc[4];
  bit mPrevEnter, mPrevExit;
  int doorLeft;
  int fullCycles;

  function automatic int freeCount(input bit [3:0] o);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!o[i]) n++;
    return n;
  endfunction

  function automatic int firstFree(input bit [3:0] o);
    for (int i = 0; i < 4; i++) if (!o[i]) return i + 1;
    return 0;
  endfunction

  function automatic int segOf(input int v);
    logic [6:0] tab [0:4];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66};
    if (v >= 0 && v <= 4) return int'(tab[v]);
    return 0;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   newOcc[4];
    bit   wasFull, acc, placed;
    if (reset) begin
      for (int i = 0; i < 4; i++) mOcc[i] = 1'b0;
      mPrevEnter = 1'b0;
      mPrevExit  = 1'b0;
      doorLeft   = 0;
      fullCycles = 0;
    end else begin
      wasFull = mOcc[0] && mOcc[1] && mOcc[2] && mOcc[3];
      newOcc  = mOcc;
      acc     = 1'b0;
      if (enter && !mPrevEnter && !wasFull) begin
        placed = 1'b0;
        for (int i = 0; i < 4; i++)
          if (!placed && !mOcc[i]) begin
            newOcc[i] = 1'b1;
            placed    = 1'b1;
          end
        acc = 1'b1;
      end
      if (exitSig && !mPrevExit && mOcc[exitLocation]) begin
        newOcc[exitLocation] = 1'b0;
        acc = 1'b1;
      end
      mPrevEnter = enter;
      mPrevExit  = exitSig;
      if (acc) doorLeft = DOOR;
      else if (doorLeft > 0) doorLeft--;
      if (wasFull) fullCycles++;
      else fullCycles = 0;
      mOcc = newOcc;
    end
    for (int i = 0; i < 4; i++) e.occ[i] = mOcc[i];
    e.door  = (doorLeft > 0);
    e.blink = (e.occ == 4'b1111) ? bit'((fullCycles / BLNK) % 2) : 1'b0;
    expQ.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("state", int'(state), int'(e.occ));
      chk("doorOpen", int'(doorOpen), int'(e.door));
      chk("blinkLED", int'(blinkLED), int'(e.blink));
      chk("isFull", int'(isFull), (e.occ == 4'b1111) ? 1 : 0);
      chk("CapacityBCD", int'(CapacityBCD), freeCount(e.occ));
      chk("Capacity", int'(Capacity), segOf(freeCount(e.occ)));
      chk("nextParkingBCD", int'(nextParkingBCD), firstFree(e.occ));
      chk("nextParking", int'(nextParking), segOf(firstFree(e.occ)));
    end
  end

  task automatic step(input logic e, input logic x, input logic [1:0] l);
    @(posedge clk);
    #2;
    enter        = e;
    exitSig      = x;
    exitLocation = l;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    #1;
    chk("init state", int'(state), 0);
    chk("init doorOpen", int'(doorOpen), 0);
    chk("init blinkLED", int'(blinkLED), 0);
    chk("init CapacityBCD", int'(CapacityBCD), 4);
    chk("init Capacity", int'(Capacity), 'h66);
    chk("init nextParkingBCD", int'(nextParkingBCD), 1);

    idle(10);
    step(1'b1, 1'b0, 2'd0); idle(6);
    repeat (3) begin
      step(1'b1, 1'b0, 2'd0); idle(3);
    end
    idle(12);
    step(1'b1, 1'b0, 2'd0); idle(4);          // full lot: entry dropped
    step(1'b0, 1'b1, 2'd2); idle(5);          // 1111 -> 1011
    step(1'b0, 1'b1, 2'd2); idle(4);          // space already free
    repeat (20) step(1'b1, 1'b0, 2'd0);
    idle(10);                                 // full again, blinking
    step(1'b1, 1'b1, 2'd0); idle(5);          // simultaneous at full: exit wins
    step(1'b0, 1'b1, 2'd1); idle(1);          // open the door, then reset mid-door

    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("reset state", int'(state), 0);
    chk("reset doorOpen", int'(doorOpen), 0);
    chk("reset blinkLED", int'(blinkLED), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)));
    idle(10);
    @(negedge clk);
    #1;
    chk("queue drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
